// File: rtl/datacache_if.sv
// Pipeline memory-stage and backing-memory signals of the data cache.
// The slave view is the cache itself; the master view is its environment.
interface datacache_if #(
   parameter int WA = 32,
   parameter int WD = 32
) ();
   logic [WA-1:0] aluresultM;
   logic          memreadM;
   logic          memwriteM;
   logic [2:0]    funct3M;
   logic [WD-1:0] writedataM;
   logic [WD-1:0] readdataM;
   logic          stall;
   logic          mem_req;
   logic          mem_we;
   logic [WA-1:0] mem_addr;
   logic [2:0]    mem_funct3;
   logic [WD-1:0] mem_wdata;
   logic [WD-1:0] mem_rdata;
   logic          mem_ack;

   modport slave (
      input  aluresultM, memreadM, memwriteM, funct3M, writedataM, mem_rdata, mem_ack,
      output readdataM, stall, mem_req, mem_we, mem_addr, mem_funct3, mem_wdata
   );

   modport master (
      output aluresultM, memreadM, memwriteM, funct3M, writedataM, mem_rdata, mem_ack,
      input  readdataM, stall, mem_req, mem_we, mem_addr, mem_funct3, mem_wdata
   );
endinterface

// File: rtl/datacache.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
//   state | meaning
//   IDLE  | serve load hits, accept a miss or store
//   FILL  | word read from backing memory, line refilled on ack
//   WRITE | store forwarded to backing memory, line merged on ack if it hits
module datacache #(
   parameter int WA  = 32,
   parameter int WD  = 32,
   parameter int IDX = 3
) (
   input logic        clk,
   input logic        rst,
   datacache_if.slave bus
);
   localparam int TW    = WA - IDX - 2;
   localparam int LINES = 2 ** IDX;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FILL  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;

   logic [1:0]       state;
   logic             wr_done;
   logic [LINES-1:0] valid;
   logic [TW-1:0]    tag_arr  [LINES];
   logic [WD-1:0]    data_arr [LINES];
   logic [WA-1:0]    req_addr;
   logic [2:0]       req_f3;
   logic [WD-1:0]    req_wdata;

   logic [IDX-1:0] idx_in, idx_req;
   logic [TW-1:0]  tag_in, tag_req;
   logic           hit_in, hit_req;
   logic           stall_c;
   logic [WD-1:0]  rdata_c;

   assign idx_in  = bus.aluresultM[IDX+1:2];
   assign tag_in  = bus.aluresultM[WA-1:IDX+2];
   assign idx_req = req_addr[IDX+1:2];
   assign tag_req = req_addr[WA-1:IDX+2];
   assign hit_in  = valid[idx_in] && (tag_arr[idx_in] == tag_in);
   assign hit_req = valid[idx_req] && (tag_arr[idx_req] == tag_req);

   function automatic logic [WD-1:0] load_ext(input logic [WD-1:0] w, input logic [1:0] off,
                                              input logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  load_ext = {{(WD-8){b[7]}}, b};
         3'b001:  load_ext = {{(WD-16){h[15]}}, h};
         3'b100:  load_ext = {{(WD-8){1'b0}}, b};
         3'b101:  load_ext = {{(WD-16){1'b0}}, h};
         default: load_ext = w;
      endcase
   endfunction

   function automatic logic [WD-1:0] store_merge(input logic [WD-1:0] w, input logic [WD-1:0] wd,
                                                 input logic [1:0] off, input logic [2:0] f3);
      logic [WD-1:0] m;
      m = w;
      case (f3)
         3'b000:  m[{off, 3'b000} +: 8] = wd[7:0];
         3'b001:  begin
            if (off[1]) m[31:16] = wd[15:0];
            else        m[15:0]  = wd[15:0];
         end
         default: m = wd;
      endcase
      return m;
   endfunction

   // wr_done marks the IDLE cycle in which the completed store is still presented
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wr_done   <= 1'b0;
         valid     <= '0;
         req_addr  <= '0;
         req_f3    <= '0;
         req_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               wr_done <= 1'b0;
               if (!wr_done) begin
                  if (bus.memwriteM) begin
                     req_addr  <= bus.aluresultM;
                     req_f3    <= bus.funct3M;
                     req_wdata <= bus.writedataM;
                     state     <= WRITE;
                  end else if (bus.memreadM && !hit_in) begin
                     req_addr  <= {bus.aluresultM[WA-1:2], 2'b00};
                     req_f3    <= 3'b010;
                     req_wdata <= bus.writedataM;
                     state     <= FILL;
                  end
               end
            end
            FILL: begin
               if (bus.mem_ack) begin
                  valid[idx_req] <= 1'b1;
                  state          <= IDLE;
               end
            end
            WRITE: begin
               if (bus.mem_ack) begin
                  wr_done <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // tag and data arrays carry no reset; valid bits gate their use
   always_ff @(posedge clk) begin
      if (state == FILL && bus.mem_ack) begin
         data_arr[idx_req] <= bus.mem_rdata;
         tag_arr[idx_req]  <= tag_req;
      end else if (state == WRITE && bus.mem_ack && hit_req) begin
         data_arr[idx_req] <= store_merge(data_arr[idx_req], req_wdata, req_addr[1:0], req_f3);
      end
   end

   always_comb begin
      stall_c = 1'b0;
      rdata_c = '0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (!wr_done) begin
                  if (bus.memwriteM) begin
                     stall_c = 1'b1;
                  end else if (bus.memreadM) begin
                     if (hit_in) rdata_c = load_ext(data_arr[idx_in], bus.aluresultM[1:0], bus.funct3M);
                     else        stall_c = 1'b1;
                  end
               end
            end
            default: stall_c = 1'b1;
         endcase
      end
   end

   assign bus.stall      = stall_c;
   assign bus.readdataM  = rdata_c;
   assign bus.mem_req    = (state == FILL) || (state == WRITE);
   assign bus.mem_we     = (state == WRITE);
   assign bus.mem_addr   = req_addr;
   assign bus.mem_funct3 = req_f3;
   assign bus.mem_wdata  = req_wdata;
endmodule

// File: tb/tb_datacache.sv
// Scoreboard bench for datacache: a memory-level reference model predicts load data,
// backing-memory transactions and stall lengths; monitors compare as outputs appear.
module tb_datacache;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   datacache_if #(.WA(32), .WD(32)) bus ();
   datacache #(.WA(32), .WD(32), .IDX(3)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [2:0]  f3;
      logic [31:0] wdata;
   } txn_t;

   txn_t        exp_txn[$];
   logic [31:0] exp_load[$];
   int          nvec = 0;
   int          nerr = 0;
   logic [31:0] mem [int];
   bit          cv [8];
   int          ct [8];
   int          ack_delay = 0;
   bit          resp_en = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_rd(input int w);
      logic [31:0] wa;
      wa = w;
      if (mem.exists(w)) return mem[w];
      return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   function automatic logic [31:0] ext_m(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
      logic [31:0] b, h;
      b = (w >> (8 * a[1:0])) & 32'hFF;
      h = (a[1] ? (w >> 16) : w) & 32'hFFFF;
      case (f3)
         3'b000:  return b[7] ? (b | 32'hFFFFFF00) : b;
         3'b001:  return h[15] ? (h | 32'hFFFF0000) : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] merge_m(input logic [31:0] w, input logic [31:0] wd,
                                           input logic [31:0] a, input logic [2:0] f3);
      logic [31:0] mask, pos;
      case (f3)
         3'b000: begin mask = 32'hFF << (8 * a[1:0]); pos = (wd & 32'hFF) << (8 * a[1:0]); end
         3'b001: begin mask = a[1] ? 32'hFFFF0000 : 32'h0000FFFF; pos = (wd & 32'hFFFF) << (a[1] ? 16 : 0); end
         default: begin mask = 32'hFFFFFFFF; pos = wd; end
      endcase
      return (w & ~mask) | (pos & mask);
   endfunction

   // backing memory: acks after ack_delay extra request cycles
   initial begin
      int cnt;
      cnt = 0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!resp_en) begin
            cnt = 0;
         end else if (bus.mem_req && !bus.mem_ack) begin
            cnt++;
            if (cnt > ack_delay) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = bus.mem_we ? $urandom : mem_rd(int'(bus.mem_addr >> 2));
               cnt = 0;
            end
         end else begin
            bus.mem_ack = 1'b0;
            cnt = 0;
         end
      end
   end

   // monitor: loads complete when stall is low; transactions start on mem_req rise
   initial begin
      logic prev;
      txn_t t;
      logic [31:0] e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.memreadM && !bus.memwriteM && !bus.stall && !rst) begin
            if (exp_load.size() == 0) begin
               nvec++; nerr++;
               $display("FAIL load_extra: got %h expected no load", bus.readdataM);
            end else begin
               e = exp_load.pop_front();
               check("load_data", bus.readdataM, e);
            end
         end
         if (bus.mem_req && !prev) begin
            if (exp_txn.size() == 0) begin
               nvec++; nerr++;
               $display("FAIL mem_extra: got addr %h we %0b expected no request", bus.mem_addr, bus.mem_we);
            end else begin
               t = exp_txn.pop_front();
               check("mem_we", 32'(bus.mem_we), 32'(t.we));
               check("mem_addr", bus.mem_addr, t.addr);
               check("mem_funct3", 32'(bus.mem_funct3), 32'(t.f3));
               if (t.we) check("mem_wdata", bus.mem_wdata, t.wdata);
            end
         end
         prev = bus.mem_req;
      end
   end

   task automatic op(input bit st, input logic [31:0] a, input logic [2:0] f3,
                     input logic [31:0] wd, input int d);
      int wi, idx, tg, exp_st, n;
      wi  = int'(a >> 2);
      idx = int'(a[4:2]);
      tg  = int'(a >> 5);
      ack_delay = d;
      if (st) begin
         exp_txn.push_back('{1'b1, a, f3, wd});
         mem[wi] = merge_m(mem_rd(wi), wd, a, f3);
         exp_st = 2 + d;
      end else begin
         if (cv[idx] && ct[idx] == tg) begin
            exp_st = 0;
         end else begin
            exp_txn.push_back('{1'b0, {a[31:2], 2'b00}, 3'b010, wd});
            cv[idx] = 1'b1;
            ct[idx] = tg;
            exp_st = 2 + d;
         end
         exp_load.push_back(ext_m(mem_rd(wi), a, f3));
      end
      @(posedge clk); #1;
      bus.aluresultM = a;
      bus.funct3M    = f3;
      bus.writedataM = wd;
      bus.memwriteM  = st;
      bus.memreadM   = !st;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.stall) break;
         n++;
      end
      check("stall_cycles", n, exp_st);
      check("req_after_done", 32'(bus.mem_req), 32'd0);
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      bus.memreadM  = 1'b0;
      bus.memwriteM = 1'b0;
   endtask

   initial begin
      bit st;
      int tg, ix, off, d;
      logic [2:0] f3;
      logic [31:0] a;
      logic [2:0] lf3 [8];
      lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

      mem[4] = 32'hDEADBEEF;
      bus.aluresultM = 32'h10;
      bus.funct3M    = 3'b010;
      bus.writedataM = '0;
      bus.memreadM   = 1'b1;
      bus.memwriteM  = 1'b0;
      #2 rst = 1'b1;
      #10;
      check("rst_stall", 32'(bus.stall), 32'd0);
      check("rst_readdata", bus.readdataM, 32'd0);
      check("rst_mem_req", 32'(bus.mem_req), 32'd0);
      check("rst_mem_we", 32'(bus.mem_we), 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_funct3", 32'(bus.mem_funct3), 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      @(posedge clk); #1;
      bus.memreadM = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("idle_readdata", bus.readdataM, 32'd0);

      op(0, 32'h10, 3'b010, 32'h0, 3);
      op(0, 32'h13, 3'b000, 32'h0, 0);
      op(0, 32'h13, 3'b100, 32'h0, 0);
      op(0, 32'h10, 3'b001, 32'h0, 0);
      op(0, 32'h12, 3'b101, 32'h0, 0);
      op(1, 32'h11, 3'b000, 32'hAA, 1);
      op(0, 32'h10, 3'b010, 32'h0, 0);
      op(1, 32'h40, 3'b010, 32'h12345678, 0);
      op(0, 32'h40, 3'b010, 32'h0, 2);
      op(0, 32'h30, 3'b010, 32'h0, 1);
      op(0, 32'h10, 3'b010, 32'h0, 1);
      go_idle();
      @(negedge clk);
      check("noreq_readdata", bus.readdataM, 32'd0);
      check("noreq_stall", 32'(bus.stall), 32'd0);

      // reset in the middle of a fill, then a stray ack
      ack_delay = 50;
      exp_txn.push_back('{1'b0, 32'h30, 3'b010, 32'h0});
      @(posedge clk); #1;
      bus.aluresultM = 32'h30;
      bus.funct3M    = 3'b010;
      bus.memreadM   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
      resp_en = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_mem_req", 32'(bus.mem_req), 32'd0);
      check("midrst_stall", 32'(bus.stall), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.memreadM = 1'b0;
      for (int i = 0; i < 8; i++) cv[i] = 1'b0;
      @(posedge clk); #1;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      check("stray_ack_req", 32'(bus.mem_req), 32'd0);
      check("stray_ack_stall", 32'(bus.stall), 32'd0);
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      resp_en = 1'b1;
      op(0, 32'h10, 3'b010, 32'h0, 0);
      op(0, 32'h00, 3'b010, 32'h0, 0);

      for (int k = 0; k < 250; k++) begin
         st  = ($urandom_range(0, 2) == 0);
         tg  = $urandom_range(0, 3);
         ix  = $urandom_range(0, 7);
         d   = $urandom_range(0, 3);
         f3  = st ? lf3[$urandom_range(0, 2)] : lf3[$urandom_range(0, 7)];
         if (f3 == 3'b001 || f3 == 3'b101) off = 2 * $urandom_range(0, 1);
         else off = $urandom_range(0, 3);
         a = (32'(tg) << 5) | (32'(ix) << 2) | 32'(off);
         op(st, a, f3, $urandom, d);
      end
      go_idle();
      repeat (3) @(negedge clk);
      check("txn_leftover", exp_txn.size(), 32'd0);
      check("load_leftover", exp_load.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
